next_pc_unit: RTL

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// Next-PC generation: sequential, branch, jump and register-jump redirects with stall handling.
// Optional branch delay slot enabled by defining NPC_DELAY_SLOT_EN.
module next_pc_unit #(
   parameter int unsigned ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IMM_W    = 16,
   parameter int unsigned JIDX_W   = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [IMM_W-1:0]  br_off,
   input  logic              jmp,
   input  logic [JIDX_W-1:0] jidx,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jr_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              redir_pend,
   output logic              align_err
);

`ifdef NPC_DELAY_SLOT_EN
   typedef enum logic [1:0] {RUN, HELD, SLOT} state_t;
`else
   typedef enum logic [1:0] {RUN, HELD} state_t;
`endif

   state_t            state, state_nx;
   logic [ADDR_W-1:0] tgt, tgt_nx, pc_nx, target;
   logic signed [ADDR_W-1:0] br_disp;
   logic              redir, align_err_nx;

   function automatic logic signed [ADDR_W-1:0] word_disp(input logic [IMM_W-1:0] off);
      return {{(ADDR_W-IMM_W-2){off[IMM_W-1]}}, off, 2'b00};
   endfunction

   assign pc_plus4   = pc + ADDR_W'(4);
   assign br_disp    = word_disp(br_off);
   assign redir      = jr | jmp | br_taken;
   assign redir_pend = (state != RUN);

   // Priority jr > jmp > branch; lower-priority requests are simply dropped.
   always_comb begin
      target = pc_plus4 + ADDR_W'(br_disp);
      if (jr)
         target = {jr_addr[ADDR_W-1:2], 2'b00};
      else if (jmp)
         target = {pc_plus4[ADDR_W-1:JIDX_W+2], jidx, 2'b00};
   end

   always_comb begin
      state_nx     = state;
      pc_nx        = pc;
      tgt_nx       = tgt;
      align_err_nx = align_err;
      case (state)
         RUN: begin
            if (redir) begin
               align_err_nx = align_err | (jr & (|jr_addr[1:0]));
               tgt_nx       = target;
               if (stall) begin
                  state_nx = HELD;
               end else begin
`ifdef NPC_DELAY_SLOT_EN
                  pc_nx    = pc_plus4;
                  state_nx = SLOT;
`else
                  pc_nx    = target;
`endif
               end
            end else if (!stall) begin
               pc_nx = pc_plus4;
            end
         end
         HELD: begin
            if (!stall) begin
`ifdef NPC_DELAY_SLOT_EN
               pc_nx    = pc_plus4;
               state_nx = SLOT;
`else
               pc_nx    = tgt;
               state_nx = RUN;
`endif
            end
         end
`ifdef NPC_DELAY_SLOT_EN
         SLOT: begin
            if (!stall) begin
               pc_nx    = tgt;
               state_nx = RUN;
            end
         end
`endif
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         pc        <= RESET_PC;
         tgt       <= '0;
         align_err <= 1'b0;
      end else begin
         state     <= state_nx;
         pc        <= pc_nx;
         tgt       <= tgt_nx;
         align_err <= align_err_nx;
      end
   end

endmodule
